alu_stim_sequencer: RTL and testbench
=====================================

Name: alu_stim_sequencer

Overview:
Upstream issue stage for the 8-bit ALU. It generates operand pairs from a 16-bit LFSR and steps the 2-bit function code through the ALU's operation schedule. It drives ALU inputs REGA/REGB/REGF directly and reads back the ALU status REGS to select the next function. A valid/ready handshake and an operation counter let a bench or controller run a bounded or free-running burst.

Parameters:
SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001 at reset.
HOLD, 0, idle cycles (VALID low) inserted after each accepted transfer; 0 means back-to-back issue.
NUM_OPS, 16, transfers per burst; 0 means free-run (never DONE).

Ports:
CLK  input  1  clock; all state updates on rising edge
RST_N  input  1  asynchronous active-low reset
START  input  1  single-cycle pulse; starts a burst from IDLE or DONE
READY  input  1  consumer accepts the current operands/function this cycle
REGS  input  2  ALU status/cycle field; sampled only on transfer
REGA  output  8  operand A = lfsr[7:0], registered
REGB  output  8  operand B = lfsr[15:8], registered
REGF  output  2  function code, registered
VALID  output  1  REGA/REGB/REGF hold a live operation
OP_COUNT  output  16  transfers completed in the current burst
DONE  output  1  sticky burst-complete flag

Behaviour:
- Reset (async assert, sync release): lfsr=SEED (or 16'h0001 if SEED==0); REGA=lfsr[7:0]; REGB=lfsr[15:8]; REGF=2'd1; VALID=0; OP_COUNT=0; DONE=0; hold counter=0; state=IDLE.
- Reset asserted mid-burst returns all state to reset values immediately. No transfer completes in that cycle.
- Transfer is defined as VALID && READY at a rising edge.
- While VALID=1 and READY=0, REGA/REGB/REGF/VALID are held stable.
- States:
  - IDLE: VALID=0. START moves to ISSUE, clears OP_COUNT and DONE, and VALID=1 next cycle.
  - ISSUE: VALID=1. On transfer:
    - advance lfsr and reload REGA/REGB from it;
    - update REGF per the function schedule;
    - OP_COUNT+1.
    - Next state: DONE if NUM_OPS!=0 and the new OP_COUNT==NUM_OPS; else WAIT if HOLD>0; else stay in ISSUE.
  - WAIT: VALID=0. Counts HOLD cycles, then goes to ISSUE.
  - DONE: VALID=0, DONE=1. START moves to ISSUE, clears OP_COUNT and DONE, and leaves lfsr and REGF unchanged (the sequence continues).
- START outside IDLE/DONE is ignored.
- LFSR step:
  - next[14:0]=cur[15:1];
  - next[15]=cur[0]^cur[2]^cur[3]^cur[5]^cur[15].
  - The lfsr advances only on transfer.
- Function schedule, using REGS sampled at the transfer edge:
  - F=0: next 2 if REGS==0, else stay 0.
  - F=1: next 3.
  - F=2: next 1 if REGS<3, else stay 2.
  - F=3: next 0.
- OP_COUNT wraps 16'hFFFF to 0 in free-run mode. A wrap never sets DONE.
- Latency: operands and function for transfer n+1 are on the outputs in the cycle after transfer n (HOLD=0). READY held high gives one op per clock.
- No combinational path from READY or REGS to any output.

Test Plan:
1. Reset with defaults -> REGA=8'hE1, REGB=8'hAC, REGF=1, VALID=0, OP_COUNT=0, DONE=0. Assert RST_N low mid-burst -> same values without waiting for a clock edge.
2. START with READY=1, REGS=0, HOLD=0 -> transfer 1 sees A=E1/B=AC/F=1; then A=70/B=D6/F=3; then A=38/B=6B/F=0; then F=2, then F=1. One transfer per clock.
3. READY=0 for 5 cycles after START -> outputs frozen at E1/AC/1 with VALID=1, OP_COUNT=0. Raise READY -> sequence resumes as in scenario 2.
4. REGS=3 when F=2 -> F stays 2 over repeated transfers; REGS=2 -> next F=1. REGS=1 when F=0 -> F stays 0; REGS=0 -> next F=2.
5. NUM_OPS=16, READY=1 -> DONE=1 and VALID=0 after the 16th transfer, OP_COUNT=16. Second START -> OP_COUNT cleared, lfsr continues from the 17th state.
6. HOLD=2 -> VALID pattern 1,0,0,1,0,0 with READY tied high. START pulses during ISSUE/WAIT have no effect.

Source files
------------

// File: rtl/alu_stim_sequencer.sv
// Issue stage for the 8-bit ALU: LFSR-generated operand pairs plus a function
// code stepped by the ALU status, released through a valid/ready handshake.
module alu_stim_sequencer #(
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int          HOLD    = 0,
    parameter int          NUM_OPS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        ready,
    input  logic [1:0]  regs,
    output logic [7:0]  rega,
    output logic [7:0]  regb,
    output logic [1:0]  regf,
    output logic        valid,
    output logic [15:0] op_count,
    output logic        done
);

    // An all-zero LFSR would lock up, so zero is replaced at reset.
    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] NUM_OPS_W = 16'(NUM_OPS);
    localparam logic [15:0] HOLD_LAST = (HOLD > 0) ? 16'(HOLD - 1) : 16'h0000;
    localparam bit          USE_LIMIT = (NUM_OPS != 0);
    localparam bit          USE_HOLD  = (HOLD > 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {cur[0] ^ cur[2] ^ cur[3] ^ cur[5] ^ cur[15], cur[15:1]};
    endfunction

    function automatic logic [1:0] func_next(input logic [1:0] f, input logic [1:0] s);
        logic [1:0] nf;
        case (f)
            2'd0:    nf = (s == 2'd0) ? 2'd2 : 2'd0;
            2'd1:    nf = 2'd3;
            2'd2:    nf = (s < 2'd3) ? 2'd1 : 2'd2;
            2'd3:    nf = 2'd0;
            default: nf = 2'd1;
        endcase
        return nf;
    endfunction

    state_t      state_r, state_s;
    logic [15:0] lfsr_r, lfsr_s;
    logic [7:0]  rega_r, regb_r;
    logic [1:0]  regf_r, regf_s;
    logic        valid_r, done_r, done_s;
    logic [15:0] cnt_r, cnt_s;
    logic [15:0] hold_r, hold_s;

    // Next-state and datapath update; all outputs are taken from registers.
    always_comb begin
        state_s = state_r;
        lfsr_s  = lfsr_r;
        regf_s  = regf_r;
        cnt_s   = cnt_r;
        done_s  = done_r;
        hold_s  = hold_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s = ST_ISSUE;
                    cnt_s   = 16'h0000;
                    done_s  = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_ISSUE: begin
                if (ready) begin
                    lfsr_s = lfsr_step(lfsr_r);
                    regf_s = func_next(regf_r, regs);
                    cnt_s  = cnt_r + 16'h0001;
                    if (USE_LIMIT && (cnt_s == NUM_OPS_W)) begin
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                    end else if (USE_HOLD) begin
                        state_s = ST_WAIT;
                        hold_s  = 16'h0000;
                    end else begin
                        state_s = ST_ISSUE;
                    end
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (hold_r == HOLD_LAST) begin
                    state_s = ST_ISSUE;
                    hold_s  = 16'h0000;
                end else begin
                    hold_s  = hold_r + 16'h0001;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; operands reload from the next LFSR value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            lfsr_r  <= SEED_EFF;
            rega_r  <= SEED_EFF[7:0];
            regb_r  <= SEED_EFF[15:8];
            regf_r  <= 2'd1;
            valid_r <= 1'b0;
            cnt_r   <= 16'h0000;
            done_r  <= 1'b0;
            hold_r  <= 16'h0000;
        end else begin
            state_r <= state_s;
            lfsr_r  <= lfsr_s;
            rega_r  <= lfsr_s[7:0];
            regb_r  <= lfsr_s[15:8];
            regf_r  <= regf_s;
            valid_r <= (state_s == ST_ISSUE);
            cnt_r   <= cnt_s;
            done_r  <= done_s;
            hold_r  <= hold_s;
        end
    end

    assign rega     = rega_r;
    assign regb     = regb_r;
    assign regf     = regf_r;
    assign valid    = valid_r;
    assign op_count = cnt_r;
    assign done     = done_r;

endmodule

// File: tb/tb_alu_stim_sequencer.sv
// Randomized self-checking bench for alu_stim_sequencer against a behavioural
// model of the issue sequence (LFSR arithmetic, function table, burst count).
module tb_alu_stim_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start, ready;
    logic [1:0]  regs;
    logic [7:0]  a0, b0, a1, b1;
    logic [1:0]  f0, f1;
    logic        v0, d0, v1, d1;
    logic [15:0] c0, c1;

    always #5 clk = ~clk;

    alu_stim_sequencer #(.SEED(16'hACE1), .HOLD(0), .NUM_OPS(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .regs(regs),
        .rega(a0), .regb(b0), .regf(f0), .valid(v0), .op_count(c0), .done(d0)
    );

    alu_stim_sequencer #(.SEED(16'hACE1), .HOLD(2), .NUM_OPS(0)) u_hold (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .regs(regs),
        .rega(a1), .regb(b1), .regf(f1), .valid(v1), .op_count(c1), .done(d1)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model of the HOLD=0 / NUM_OPS=16 instance
    int m_lfsr, m_f, m_cnt;
    bit m_valid, m_done;

    function automatic int lfsr_next(input int x);
        int fb;
        fb = (x ^ (x >> 2) ^ (x >> 3) ^ (x >> 5) ^ (x >> 15)) & 1;
        return ((x >> 1) | (fb << 15)) & 32'hFFFF;
    endfunction

    function automatic int f_next(input int f, input int s);
        if (f == 0) return (s == 0) ? 2 : 0;
        if (f == 1) return 3;
        if (f == 2) return (s < 3) ? 1 : 2;
        return 0;
    endfunction

    function automatic logic [35:0] model_vec();
        logic [15:0] l, c;
        logic [1:0]  f;
        l = m_lfsr[15:0];
        c = m_cnt[15:0];
        f = m_f[1:0];
        return {l[7:0], l[15:8], f, m_valid, c, m_done};
    endfunction

    wire [35:0] dut_vec = {a0, b0, f0, v0, c0, d0};

    task automatic model_reset();
        m_lfsr = 32'hACE1; m_f = 1; m_cnt = 0; m_valid = 1'b0; m_done = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; ready = 1'b0; regs = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Drive one clock with the given inputs and advance the model.
    task automatic cycle(input bit st, input bit r, input int s);
        start = st; ready = r; regs = s[1:0];
        @(posedge clk);
        if (st && !m_valid) begin
            m_valid = 1'b1; m_cnt = 0; m_done = 1'b0;
        end else if (m_valid && r) begin
            m_lfsr = lfsr_next(m_lfsr);
            m_f    = f_next(m_f, s);
            m_cnt  = (m_cnt + 1) & 32'hFFFF;
            if (m_cnt == 16) begin
                m_valid = 1'b0; m_done = 1'b1;
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (dut_vec !== {8'hE1, 8'hAC, 2'd1, 1'b0, 16'd0, 1'b0}) begin
            n_fail++; $display("FAIL reset_values: got %h want %h", dut_vec, {8'hE1, 8'hAC, 2'd1, 1'b0, 16'd0, 1'b0});
        end
        cycle(1'b1, 1'b1, 0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 0);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dut_vec !== {8'hE1, 8'hAC, 2'd1, 1'b0, 16'd0, 1'b0}) begin
            n_fail++; $display("FAIL async_reset: got %h want %h", dut_vec, {8'hE1, 8'hAC, 2'd1, 1'b0, 16'd0, 1'b0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_sequence();
        logic [1:0] exp_f [4] = '{2'd3, 2'd0, 2'd2, 2'd1};
        do_reset();
        cycle(1'b1, 1'b1, 0);
        n_cmp++;
        if (dut_vec !== {8'hE1, 8'hAC, 2'd1, 1'b1, 16'd0, 1'b0}) begin
            n_fail++; $display("FAIL seq_first: got %h want %h", dut_vec, {8'hE1, 8'hAC, 2'd1, 1'b1, 16'd0, 1'b0});
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 0);
            n_cmp++;
            if (f0 !== exp_f[i] || c0 !== 16'(i + 1) || v0 !== 1'b1) begin
                n_fail++; $display("FAIL seq_func[%0d]: got f=%0d cnt=%0d v=%b want f=%0d cnt=%0d v=1", i, f0, c0, v0, exp_f[i], i + 1);
            end
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL seq_model[%0d]: got %h want %h", i, dut_vec, model_vec());
            end
            if (i == 0) begin
                n_cmp++;
                if ({b0, a0} !== 16'hD670) begin
                    n_fail++; $display("FAIL seq_ops1: got %h want d670", {b0, a0});
                end
            end
            if (i == 1) begin
                n_cmp++;
                if ({b0, a0} !== 16'h6B38) begin
                    n_fail++; $display("FAIL seq_ops2: got %h want 6b38", {b0, a0});
                end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        cycle(1'b1, 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, $urandom_range(0, 3));
            n_cmp++;
            if (dut_vec !== {8'hE1, 8'hAC, 2'd1, 1'b1, 16'd0, 1'b0}) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got %h want %h", i, dut_vec, {8'hE1, 8'hAC, 2'd1, 1'b1, 16'd0, 1'b0});
            end
        end
        cycle(1'b0, 1'b1, 0);
        n_cmp++;
        if (dut_vec !== {8'h70, 8'hD6, 2'd3, 1'b1, 16'd1, 1'b0}) begin
            n_fail++; $display("FAIL stall_resume1: got %h want %h", dut_vec, {8'h70, 8'hD6, 2'd3, 1'b1, 16'd1, 1'b0});
        end
        cycle(1'b0, 1'b1, 0);
        n_cmp++;
        if (dut_vec !== {8'h38, 8'h6B, 2'd0, 1'b1, 16'd2, 1'b0}) begin
            n_fail++; $display("FAIL stall_resume2: got %h want %h", dut_vec, {8'h38, 8'h6B, 2'd0, 1'b1, 16'd2, 1'b0});
        end
    endtask

    task automatic test_func_regs();
        int s_list [13] = '{0, 0, 0, 3, 3, 3, 2, 0, 0, 1, 1, 1, 0};
        int f_list [13] = '{3, 0, 2, 2, 2, 2, 1, 3, 0, 0, 0, 0, 2};
        do_reset();
        cycle(1'b1, 1'b1, 0);
        for (int i = 0; i < 13; i++) begin
            cycle(1'b0, 1'b1, s_list[i]);
            n_cmp++;
            if (f0 !== 2'(f_list[i])) begin
                n_fail++; $display("FAIL func_regs[%0d]: got f=%0d want f=%0d", i, f0, f_list[i]);
            end
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL func_model[%0d]: got %h want %h", i, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_burst_done();
        int budget;
        int s17;
        do_reset();
        cycle(1'b1, 1'b1, 0);
        budget = 0;
        while (!m_done && budget < 200) begin
            cycle(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL burst_model[%0d]: got %h want %h", budget, dut_vec, model_vec());
            end
            budget++;
        end
        n_cmp++;
        if (budget >= 200) begin
            n_fail++; $display("FAIL burst_timeout: got %0d cycles want <200", budget);
        end
        n_cmp++;
        if (v0 !== 1'b0 || d0 !== 1'b1 || c0 !== 16'd16) begin
            n_fail++; $display("FAIL burst_done: got v=%b d=%b cnt=%0d want v=0 d=1 cnt=16", v0, d0, c0);
        end
        s17 = 32'hACE1;
        for (int i = 0; i < 16; i++) s17 = lfsr_next(s17);
        cycle(1'b1, 1'b0, 0);
        n_cmp++;
        if (v0 !== 1'b1 || d0 !== 1'b0 || c0 !== 16'd0 || {b0, a0} !== s17[15:0]) begin
            n_fail++; $display("FAIL burst_restart: got v=%b d=%b cnt=%0d ops=%h want v=1 d=0 cnt=0 ops=%h", v0, d0, c0, {b0, a0}, s17[15:0]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0), $urandom_range(0, 3));
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL random[%0d]: got %h want %h", i, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_hold();
        int h_lfsr, h_cnt;
        bit st;
        do_reset();
        h_lfsr = 32'hACE1; h_cnt = 0;
        cycle(1'b1, 1'b1, 0);
        for (int i = 0; i < 12; i++) begin
            n_cmp++;
            if (v1 !== 1'((i % 3) == 0) || c1 !== h_cnt[15:0] || {b1, a1} !== h_lfsr[15:0]) begin
                n_fail++; $display("FAIL hold[%0d]: got v=%b cnt=%0d ops=%h want v=%b cnt=%0d ops=%h", i, v1, c1, {b1, a1}, (i % 3) == 0, h_cnt, h_lfsr[15:0]);
            end
            st = (i == 3 || i == 4) ? 1'b1 : ((i > 0) ? 1'($urandom_range(0, 1)) : 1'b0);
            cycle(st, 1'b1, 0);
            if ((i % 3) == 0) begin
                h_lfsr = lfsr_next(h_lfsr);
                h_cnt++;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; ready = 1'b0; regs = 2'd0;
        model_reset();
        test_reset();
        test_sequence();
        test_stall();
        test_func_regs();
        test_burst_done();
        test_random();
        test_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
